// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, converter states and float field helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    CVT_IDLE  = 2'd0,
    CVT_NORM  = 2'd1,
    CVT_ROUND = 2'd2
  } cvt_state_t;

  localparam int unsigned FLT_EXP_W = 8;
  localparam int unsigned FLT_MAN_W = 23;

  // Single-precision result fields; parametrised users build their own layout.
  typedef struct packed {
    logic                 sign;
    logic [FLT_EXP_W-1:0] exp;
    logic [FLT_MAN_W-1:0] frac;
  } flt_s_t;

  function automatic int unsigned flt_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fpu_round_inc.sv
// Rounding-increment decision shared by the FPU conversion and add paths.
module fpu_round_inc
  import fpu_pkg::*;
(
  input  rm_e  rm,
  input  logic sign,
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic inc_c
);

  always_comb begin
    inc_c = 1'b0;
    case (rm)
      RM_RNE:  inc_c = guard & (sticky | lsb);
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = sign & (guard | sticky);
      RM_RUP:  inc_c = ~sign & (guard | sticky);
      RM_RMM:  inc_c = guard;
      default: inc_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_int2flt_seq.sv
// Multi-cycle integer-to-float converter with an iterative normaliser and
// start/busy/valid handshake.
module fpu_int2flt_seq
  import fpu_pkg::*;
#(
  parameter int unsigned INT_W      = 32,
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 23,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [INT_W-1:0]         opa,
  input  logic                     is_signed,
  input  logic [2:0]               flt_rm,
  output logic [EXP_W+MAN_W:0]     fpu_res,
  output logic                     fpu_valid,
  output logic                     fpu_busy,
  output logic                     fflags_nx
);

  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
  localparam int unsigned EXT_W = INT_W + MAN_W + 1;
  localparam int unsigned LZ_W  = $clog2(SHIFT_STEP + 1);

  localparam logic [1:0] IDLE  = 2'(CVT_IDLE);
  localparam logic [1:0] NORM  = 2'(CVT_NORM);
  localparam logic [1:0] ROUND = 2'(CVT_ROUND);

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [INT_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  rm_e              rm_q, rm_d;
  logic [RES_W-1:0] res_d;
  logic             valid_d;
  logic             nx_d;

  logic [SHIFT_STEP-1:0] win;
  logic [LZ_W-1:0]       lz;
  logic [EXT_W-1:0]      ext;
  logic [MAN_W-1:0]      frac;
  logic                  guard, sticky, inc;
  logic [MAN_W:0]        frac_sum;
  logic [EXP_W-1:0]      exp_rnd;

  // Leading-zero count within the top window; the highest set bit wins.
  assign win = mag_q[INT_W-1 -: SHIFT_STEP];
  always_comb begin
    lz = '0;
    for (int i = 0; i < int'(SHIFT_STEP); i++) begin
      if (win[i]) lz = LZ_W'(int'(SHIFT_STEP) - 1 - i);
    end
  end

  // Zero padding below the magnitude makes guard/sticky vanish when MAN_W covers it.
  assign ext      = {mag_q[INT_W-2:0], {(MAN_W + 2){1'b0}}};
  assign frac     = ext[EXT_W-1 -: MAN_W];
  assign guard    = ext[EXT_W-1-MAN_W];
  assign sticky   = |ext[EXT_W-2-MAN_W:0];
  assign frac_sum = {1'b0, frac} + (MAN_W + 1)'(inc);
  assign exp_rnd  = exp_q + EXP_W'(frac_sum[MAN_W]);

  fpu_round_inc u_round_inc (
    .rm     (rm_q),
    .sign   (sign_q),
    .lsb    (frac[0]),
    .guard  (guard),
    .sticky (sticky),
    .inc_c  (inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      rm_q      <= RM_RNE;
      fpu_res   <= '0;
      fpu_valid <= 1'b0;
      fpu_busy  <= 1'b0;
      fflags_nx <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      rm_q      <= rm_d;
      fpu_res   <= res_d;
      fpu_valid <= valid_d;
      fpu_busy  <= (state_d != IDLE);
      fflags_nx <= nx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    rm_d    = rm_q;
    res_d   = fpu_res;
    valid_d = 1'b0;
    nx_d    = fflags_nx;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = is_signed & opa[INT_W-1];
          mag_d   = sign_d ? INT_W'(-opa) : opa;
          exp_d   = EXP_W'(flt_bias(EXP_W) + INT_W - 1);
          rm_d    = (flt_rm > 3'd4) ? RM_RNE : rm_e'(flt_rm);
          state_d = (mag_d == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (win == '0) begin
          mag_d = mag_q << SHIFT_STEP;
          exp_d = exp_q - EXP_W'(SHIFT_STEP);
        end else begin
          mag_d   = mag_q << lz;
          exp_d   = exp_q - EXP_W'(lz);
          state_d = ROUND;
        end
      end
      ROUND: begin
        // A normalised magnitude always has its MSB set; clear MSB means zero input.
        if (!mag_q[INT_W-1]) begin
          res_d = '0;
          nx_d  = 1'b0;
        end else begin
          res_d = {sign_q, exp_rnd, frac_sum[MAN_W-1:0]};
          nx_d  = guard | sticky;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
